// File: rtl/clken_div_pkg.sv
// Shared defaults and helpers for the clock-enable divider bank.
// The optional toggle outputs are enabled by the macro CLKEN_DIV_TOGGLE_EN.
package clken_div_pkg;

  localparam int CW_DEF          = 16;
  localparam int DIV_RST_DEF     = 2;
  localparam int LOCK_CYCLES_DEF = 16;
  localparam int LOCK_W_DEF      = $clog2(LOCK_CYCLES_DEF + 1);

  // Width of a counter that must reach the value 'cycles' inclusive.
  function automatic int lock_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/clken_chan.sv
// One divider channel: divisor register, period counter, registered ce strobe
// and, when CLKEN_DIV_TOGGLE_EN is defined, a square-wave toggle flop.
module clken_chan
  import clken_div_pkg::*;
#(
  parameter int CW      = CW_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic          clkin,
  input  logic          rst,
  input  logic          en,
  input  logic          div_load,
  input  logic [CW-1:0] div_new,
  output logic          ce,
  output logic          tgl
);

  logic [CW-1:0] div_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] last;
  logic          wrap;

  // Divisor 0 is treated as 1, so the terminal count is never negative.
  function automatic logic [CW-1:0] last_count(input logic [CW-1:0] d);
    return (d == '0) ? '0 : d - CW'(1);
  endfunction

  assign last = last_count(div_q);
  assign wrap = (cnt >= last);

  always_ff @(posedge clkin) begin
    if (rst) begin
      div_q <= CW'(DIV_RST);
      cnt   <= '0;
      ce    <= 1'b0;
    end else if (div_load) begin
      div_q <= div_new;
      cnt   <= '0;
      ce    <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      ce  <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      ce  <= 1'b1;
    end else begin
      cnt <= cnt + CW'(1);
      ce  <= 1'b0;
    end
  end

`ifdef CLKEN_DIV_TOGGLE_EN
  // Flips on the same edge that raises ce, so it runs at clkin/(2*D).
  always_ff @(posedge clkin) begin
    if (rst || div_load) begin
      tgl <= 1'b0;
    end else if (en && wrap) begin
      tgl <= ~tgl;
    end
  end
`else
  assign tgl = 1'b0;
`endif

endmodule

// File: rtl/clken_div.sv
// Multi-channel clock-enable divider with a shared settle/lock indicator.
// Define CLKEN_DIV_TOGGLE_EN to build the per-channel toggle outputs.
module clken_div
  import clken_div_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int CW          = CW_DEF,
  parameter int DIV_RST     = DIV_RST_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic [NCH-1:0]    en,
  input  logic [NCH*CW-1:0] div_i,
  input  logic              div_load,
  output logic [NCH-1:0]    ce,
  output logic [NCH-1:0]    tgl,
  output logic              locked
);

  localparam int LW = lock_w(LOCK_CYCLES);

  logic [LW-1:0] lock_cnt;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    clken_chan #(
      .CW      (CW),
      .DIV_RST (DIV_RST)
    ) u_chan (
      .clkin    (clkin),
      .rst      (rst),
      .en       (en[k]),
      .div_load (div_load),
      .div_new  (div_i[k*CW +: CW]),
      .ce       (ce[k]),
      .tgl      (tgl[k])
    );
  end

  // Every restart resets all channel phases together, so one shared counter
  // measuring edges since the last restart is enough to flag alignment.
  always_ff @(posedge clkin) begin
    if (rst || div_load) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (lock_cnt != LW'(LOCK_CYCLES)) begin
      lock_cnt <= lock_cnt + LW'(1);
      locked   <= (lock_cnt == LW'(LOCK_CYCLES - 1));
    end
  end

endmodule
